// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end for a shared WIDTH-bit wrapping adder.
// A 3-state FSM (IDLE/EXEC/RESP) drives registered gnt/done handshake outputs and the result.
module adder_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  output logic             gnt0,
  output logic             done0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             gnt1,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic             owner;
  logic             last_owner;
  logic             win1;

  // Requester 1 wins when it is alone, or on a tie when 0 owned the adder last.
  always_comb begin
    win1 = req1 & (~req0 | ~last_owner);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_x       <= '0;
      op_y       <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      result     <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            owner <= win1;
            op_x  <= win1 ? x1 : x0;
            op_y  <= win1 ? y1 : y0;
            gnt0  <= ~win1;
            gnt1  <= win1;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          result <= op_x + op_y;
          done0  <= ~owner;
          done1  <= owner;
          state  <= RESP;
        end
        RESP: begin
          done0      <= 1'b0;
          done1      <= 1'b0;
          busy       <= 1'b0;
          last_owner <= owner;
          state      <= IDLE;
        end
        default: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
Shares one WIDTH-bit adder between two requesters using round-robin arbitration and a req/gnt/done handshake. It latches the winning requester's operands and performs the wrapping add in an internal registered datapath. It returns a registered result with a one-cycle done pulse to the owner. It sits in front of the 8-bit adder datapath and is the only block that drives its operands.

Parameters:
WIDTH, 8, operand and result width in bits.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 request, level
x0  input  WIDTH  requester 0 operand x
y0  input  WIDTH  requester 0 operand y
gnt0  output  1  requester 0 granted; operands latched
done0  output  1  requester 0 result valid, 1-cycle pulse
req1  input  1  requester 1 request, level
x1  input  WIDTH  requester 1 operand x
y1  input  WIDTH  requester 1 operand y
gnt1  output  1  requester 1 granted
done1  output  1  requester 1 result valid, 1-cycle pulse
result  output  WIDTH  sum of the last completed transaction
busy  output  1  high whenever the state is not IDLE

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n). All state is updated on the rising edge of clk.
- Reset values: state=IDLE, gnt0=gnt1=0, done0=done1=0, result=0, busy=0, operand regs=0, last_owner=1. With last_owner=1, requester 0 wins the first tie.
- FSM states: IDLE, EXEC, RESP. All outputs are registered.
- IDLE:
  - If any req is high, select a winner:
    - If only one req is high, that requester wins.
    - If both are high, the requester that is not last_owner wins.
  - Latch the winner's x/y into op_x/op_y.
  - Record the owner and go to EXEC.
  - If no req is high, stay in IDLE.
- EXEC:
  - gnt of the owner is high for exactly this cycle.
  - result <= (op_x + op_y) mod 2^WIDTH. The carry is discarded.
  - Go to RESP.
- RESP:
  - done of the owner is high for exactly this cycle. result is valid.
  - last_owner <= owner.
  - Go to IDLE.
- Latency: req sampled high at edge N, then gnt high during cycle N+1, then done high and result valid during cycle N+2. The earliest next sample is edge N+3.
- Throughput: one operation per 3 cycles.
- result holds its value until the next EXEC. It is not cleared by IDLE.
- req is sampled only in IDLE. A req held high through done is treated as a new request.
- Under continuous contention, grants alternate 0,1,0,1.
- Operands are captured only at the IDLE to EXEC transition. x/y changes after that edge have no effect on the in-flight transaction.
- At most one of gnt0/gnt1 is high in any cycle. The same holds for done0/done1. gnt and done never overlap.
- A req that drops during EXEC or RESP does not cancel the transaction; done is still issued.
- rst_n asserted mid-transaction:
  - Outputs clear immediately.
  - No done is issued for the aborted operation.
  - last_owner returns to 1.
- Width rule: all arithmetic is unsigned WIDTH-bit, wrap-around on overflow.

Test Plan:
1. Reset: assert rst_n=0 with random inputs -> gnt0/1=0, done0/1=0, result=8'h00, busy=0, held asynchronously without a clock edge.
2. Single request: req0=1, x0=8'h12, y0=8'h34 -> gnt0 at +1 cycle, done0 at +2 with result=8'h46, busy high for 2 cycles, no gnt1/done1.
3. Overflow:
   - req1 with x1=8'hFF, y1=8'h01 -> done1 with result=8'h00.
   - x1=8'hC8, y1=8'h64 -> result=8'h2C.
4. Contention: req0 and req1 held high, x0=10/y0=20, x1=05/y1=06 -> done sequence 0,1,0,1 with results 8'h30, 8'h0B alternating, each 3 cycles apart.
5. Operand stability: req0 x0=8'h01, y0=8'h02, then change x0 to 8'hF0 in the cycle after the sample edge -> result=8'h03.
6. Reset mid-op: pulse rst_n low during EXEC of a req1 transaction -> no done1, state IDLE; then simultaneous req0/req1 -> req0 granted first.
